mult_div_unit: RTL and testbench

//   Multi-cycle multiply/divide unit (MDU) in the EX stage, beside the single-cycle ALU.
//   The ALU returns its result the same cycle; the MDU accepts a start, holds busy, and

---
 rtl/mdu_pkg.sv | 32 +++
 rtl/mdu_calc.sv | 63 ++++++
 rtl/mult_div_unit.sv | 124 ++++++++++++
 tb/tb_mult_div_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM states,
// write-back modes and default latencies.
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;
    localparam logic [3:0] MDU_MADD  = 4'd7;
    localparam logic [3:0] MDU_MADDU = 4'd8;
    localparam logic [3:0] MDU_MSUB  = 4'd9;
    localparam logic [3:0] MDU_MSUBU = 4'd10;

    localparam int unsigned MDU_MULT_CYCLES = 5;
    localparam int unsigned MDU_DIV_CYCLES  = 10;

    typedef enum logic {
        IDLE,
        RUN
    } mdu_state_t;

    // How the pending 64-bit result is merged into {hi,lo} at commit.
    typedef enum logic [1:0] {
        WB_SET,
        WB_ADD,
        WB_SUB
    } mdu_wb_t;

endpackage

// File: rtl/mdu_calc.sv
// Combinational MDU datapath: 64-bit {hi,lo} result for the selected operation
// plus a divide-by-zero flag. Optional MADD/MSUB products under MDU_MADD_EN.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_zero
);

    logic [63:0] sprod;
    logic [63:0] uprod;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] mag_q;
    logic [31:0] mag_r;
    logic [31:0] sq;
    logic [31:0] sr;
    logic [31:0] uq;
    logic [31:0] ur;

    always_comb begin
        sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        uprod = {32'b0, a} * {32'b0, b};

        // Signed divide on magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
        mag_a = a[31] ? -a : a;
        mag_b = b[31] ? -b : b;
        mag_q = (mag_b == '0) ? '0 : mag_a / mag_b;
        mag_r = (mag_b == '0) ? '0 : mag_a % mag_b;
        sq    = (a[31] ^ b[31]) ? -mag_q : mag_q;
        sr    = a[31] ? -mag_r : mag_r;

        uq = (b == '0) ? '0 : a / b;
        ur = (b == '0) ? '0 : a % b;

        result   = '0;
        div_zero = 1'b0;
        case (op)
            MDU_MULT:  result = sprod;
            MDU_MULTU: result = uprod;
            MDU_DIV: begin
                result   = {sr, sq};
                div_zero = (b == '0);
            end
            MDU_DIVU: begin
                result   = {ur, uq};
                div_zero = (b == '0);
            end
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MSUB:   result = sprod;
            MDU_MADDU, MDU_MSUBU: result = uprod;
`endif
            default: begin
                result   = '0;
                div_zero = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Define MDU_MADD_EN to add the MADD/MADDU/MSUB/MSUBU accumulate operations.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    mdu_state_t  state;
    mdu_state_t  next_state;
    logic [CW-1:0] cnt;
    logic [63:0] pend;
    logic        pend_dz;
    mdu_wb_t     pend_wb;

    logic [63:0] calc_res;
    logic        calc_dz;
    logic        is_div;
    logic        is_long;
    mdu_wb_t     wb_sel;
    logic        launch;
    logic        commit;

    mdu_calc u_calc (
        .op       (mdu_op),
        .a        (a),
        .b        (b),
        .result   (calc_res),
        .div_zero (calc_dz)
    );

    always_comb begin
        is_div  = (mdu_op == MDU_DIV) || (mdu_op == MDU_DIVU);
        is_long = is_div || (mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU);
        wb_sel  = WB_SET;
`ifdef MDU_MADD_EN
        if ((mdu_op == MDU_MADD) || (mdu_op == MDU_MADDU)) begin
            is_long = 1'b1;
            wb_sel  = WB_ADD;
        end else if ((mdu_op == MDU_MSUB) || (mdu_op == MDU_MSUBU)) begin
            is_long = 1'b1;
            wb_sel  = WB_SUB;
        end
`endif
    end

    always_comb begin
        next_state = state;
        launch     = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (start && is_long) begin
                    next_state = RUN;
                    launch     = 1'b1;
                end
            end
            RUN: begin
                if (cnt == CW'(1)) begin
                    next_state = IDLE;
                    commit     = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Accumulate ops read {hi,lo} at commit time, not when launched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            pend    <= '0;
            pend_dz <= 1'b0;
            pend_wb <= WB_SET;
            hi      <= '0;
            lo      <= '0;
        end else if (launch) begin
            pend    <= calc_res;
            pend_dz <= calc_dz;
            pend_wb <= wb_sel;
            cnt     <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (state == RUN) begin
            cnt <= cnt - CW'(1);
            if (commit && !pend_dz) begin
                case (pend_wb)
                    WB_ADD:  {hi, lo} <= {hi, lo} + pend;
                    WB_SUB:  {hi, lo} <= {hi, lo} - pend;
                    default: {hi, lo} <= pend;
                endcase
            end
        end else if (start) begin
            if (mdu_op == MDU_MTHI) begin
                hi <= a;
            end else if (mdu_op == MDU_MTLO) begin
                lo <= a;
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, multi-cycle corner
// sequences and randomized operations against a plain-arithmetic reference model.
module tb_mult_div_unit;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int unsigned nvec = 0;
    int unsigned nmis = 0;

    mult_div_unit #(
        .MULT_CYCLES (MDU_MULT_CYCLES),
        .DIV_CYCLES  (MDU_DIV_CYCLES)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mdu_op (mdu_op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        int unsigned ec;
    } vec_t;

    vec_t tbl[$];

    logic [31:0] mhi;
    logic [31:0] mlo;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        start  = 1'b1;
        mdu_op = op;
        a      = va;
        b      = vb;
        @(negedge clk);
        start  = 1'b0;
        mdu_op = MDU_NONE;
    endtask

    task automatic wait_idle(output int unsigned n);
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        int unsigned n;
        issue(v.op, v.a, v.b);
        wait_idle(n);
        check({tag, " cycles"}, 64'(n), 64'(v.ec));
        check({tag, " hi"}, 64'(hi), 64'(v.eh));
        check({tag, " lo"}, 64'(lo), 64'(v.el));
    endtask

    task automatic do_reset();
        start  = 1'b0;
        mdu_op = MDU_NONE;
        reset  = 1'b1;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
    endtask

    // Architectural behaviour from plain integer arithmetic.
    task automatic ref_op(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                          inout logic [31:0] h, inout logic [31:0] l,
                          output int unsigned cyc);
        int    ia;
        int    ib;
        longint sa;
        longint sb;
        longint unsigned ua;
        longint unsigned ub;
        ia = va; ib = vb;
        sa = ia; sb = ib;
        ua = {32'b0, va}; ub = {32'b0, vb};
        cyc = 0;
        case (op)
            MDU_MULT:  begin {h, l} = sa * sb; cyc = MDU_MULT_CYCLES; end
            MDU_MULTU: begin {h, l} = ua * ub; cyc = MDU_MULT_CYCLES; end
            MDU_DIV: begin
                if (vb != 0) begin
                    l = 32'(sa / sb);
                    h = 32'(sa % sb);
                end
                cyc = MDU_DIV_CYCLES;
            end
            MDU_DIVU: begin
                if (vb != 0) begin
                    l = va / vb;
                    h = va % vb;
                end
                cyc = MDU_DIV_CYCLES;
            end
            MDU_MTHI: h = va;
            MDU_MTLO: l = va;
`ifdef MDU_MADD_EN
            MDU_MADD:  begin {h, l} = {h, l} + 64'(sa * sb); cyc = MDU_MULT_CYCLES; end
            MDU_MADDU: begin {h, l} = {h, l} + (ua * ub);    cyc = MDU_MULT_CYCLES; end
            MDU_MSUB:  begin {h, l} = {h, l} - 64'(sa * sb); cyc = MDU_MULT_CYCLES; end
            MDU_MSUBU: begin {h, l} = {h, l} - (ua * ub);    cyc = MDU_MULT_CYCLES; end
`endif
            default: cyc = 0;
        endcase
    endtask

    initial begin
        int unsigned n;
        int unsigned ec;
        logic [3:0]  ops[$];
        logic [3:0]  op;
        logic [31:0] ra;
        logic [31:0] rb;

        start = 1'b0; mdu_op = MDU_NONE; a = '0; b = '0;
        reset = 1'b1;
        #12;
        check("reset busy", 64'(busy), 64'(0));
        check("reset hi", 64'(hi), 64'(0));
        check("reset lo", 64'(lo), 64'(0));
        @(negedge clk);
        reset = 1'b0;

        tbl.push_back('{MDU_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, MDU_MULT_CYCLES});
        tbl.push_back('{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MDU_MULT_CYCLES});
        tbl.push_back('{MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, MDU_DIV_CYCLES});
        tbl.push_back('{MDU_DIVU,  32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, MDU_DIV_CYCLES});
        tbl.push_back('{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, MDU_DIV_CYCLES});
        tbl.push_back('{MDU_MTHI,  32'h00001234, 32'd0,        32'h00001234, 32'h80000000, 0});
        tbl.push_back('{MDU_MTLO,  32'h00005678, 32'd0,        32'h00001234, 32'h00005678, 0});
        tbl.push_back('{MDU_DIV,   32'h00000064, 32'd0,        32'h00001234, 32'h00005678, MDU_DIV_CYCLES});
        tbl.push_back('{MDU_DIVU,  32'hFFFFFFFF, 32'd0,        32'h00001234, 32'h00005678, MDU_DIV_CYCLES});
        tbl.push_back('{MDU_NONE,  32'hDEADBEEF, 32'd1,        32'h00001234, 32'h00005678, 0});
        tbl.push_back('{4'hF,      32'hDEADBEEF, 32'd1,        32'h00001234, 32'h00005678, 0});
        tbl.push_back('{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MDU_MULT_CYCLES});
        tbl.push_back('{MDU_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, MDU_DIV_CYCLES});

        foreach (tbl[i]) run_vec($sformatf("tbl%0d", i), tbl[i]);

        // Back-to-back MTHI/MTLO: no busy, each lands one edge later.
        @(negedge clk);
        start = 1'b1; mdu_op = MDU_MTHI; a = 32'h0000ABCD;
        @(negedge clk);
        check("b2b busy1", 64'(busy), 64'(0));
        check("b2b hi", 64'(hi), 64'h0000ABCD);
        mdu_op = MDU_MTLO; a = 32'h0000DCBA;
        @(negedge clk);
        start = 1'b0; mdu_op = MDU_NONE;
        check("b2b busy2", 64'(busy), 64'(0));
        check("b2b lo", 64'(lo), 64'h0000DCBA);

        // Starts while busy are ignored.
        issue(MDU_MULT, 32'd6, 32'd7);
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            n++;
            if (n == 1) begin
                start = 1'b1; mdu_op = MDU_MTHI; a = 32'hDEAD0000;
            end else if (n == 2) begin
                mdu_op = MDU_DIV; a = 32'd1000; b = 32'd3;
            end else begin
                start = 1'b0; mdu_op = MDU_NONE;
            end
            @(negedge clk);
        end
        start = 1'b0; mdu_op = MDU_NONE;
        check("ign cycles", 64'(n), 64'(MDU_MULT_CYCLES));
        check("ign hi", 64'(hi), 64'(0));
        check("ign lo", 64'(lo), 64'(42));
        @(negedge clk);
        check("ign idle", 64'(busy), 64'(0));

        // Asynchronous reset in the third busy cycle.
        issue(MDU_MTHI, 32'h0000AAAA, 32'd0);
        issue(MDU_MULT, 32'd9, 32'd9);
        @(negedge clk);
        @(negedge clk);
        check("rst pre busy", 64'(busy), 64'(1));
        #2 reset = 1'b1;
        #1;
        check("rst busy", 64'(busy), 64'(0));
        check("rst hi", 64'(hi), 64'(0));
        check("rst lo", 64'(lo), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("rst lost busy", 64'(busy), 64'(0));
        check("rst lost lo", 64'(lo), 64'(0));

        // Accumulate ops (inert unless MDU_MADD_EN).
        do_reset();
        issue(MDU_MTLO, 32'd10, 32'd0);
`ifdef MDU_MADD_EN
        run_vec("madd",  '{MDU_MADD,  32'd3, 32'd4, 32'h0, 32'd22, MDU_MULT_CYCLES});
        run_vec("msub",  '{MDU_MSUB,  32'd3, 32'd4, 32'h0, 32'd10, MDU_MULT_CYCLES});
        run_vec("msubu", '{MDU_MSUBU, 32'd1, 32'd100, 32'hFFFFFFFF, 32'hFFFFFFA6, MDU_MULT_CYCLES});
        run_vec("maddu", '{MDU_MADDU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFA4, MDU_MULT_CYCLES});
`else
        run_vec("madd",  '{MDU_MADD,  32'd3, 32'd4, 32'h0, 32'd10, 0});
        run_vec("msub",  '{MDU_MSUB,  32'd3, 32'd4, 32'h0, 32'd10, 0});
        run_vec("msubu", '{MDU_MSUBU, 32'd1, 32'd100, 32'h0, 32'd10, 0});
        run_vec("maddu", '{MDU_MADDU, 32'hFFFFFFFF, 32'd2, 32'h0, 32'd10, 0});
`endif

        // Randomized operations against the reference model.
        do_reset();
        mhi = '0;
        mlo = '0;
        ops = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO, MDU_NONE};
`ifdef MDU_MADD_EN
        ops.push_back(MDU_MADD);
        ops.push_back(MDU_MADDU);
        ops.push_back(MDU_MSUB);
        ops.push_back(MDU_MSUBU);
`endif
        for (int i = 0; i < 80; i++) begin
            op = ops[$urandom_range(ops.size() - 1)];
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(7) == 0) rb = '0;
            if ($urandom_range(7) == 0) ra = 32'h80000000;
            if ($urandom_range(7) == 0) rb = 32'hFFFFFFFF;
            if ($urandom_range(3) == 0) rb = rb & 32'h000000FF;
            ref_op(op, ra, rb, mhi, mlo, ec);
            issue(op, ra, rb);
            wait_idle(n);
            check($sformatf("rand%0d op%0d cycles", i, op), 64'(n), 64'(ec));
            check($sformatf("rand%0d op%0d hi", i, op), 64'(hi), 64'(mhi));
            check($sformatf("rand%0d op%0d lo", i, op), 64'(lo), 64'(mlo));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
